// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port block memory between instruction fetch and load/store.
// Sequences plain reads, full-word writes and read-modify-write for partial-lane stores.
module memory_arbiter #(
    parameter int ADDRESS_SIZE = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    fetch_request,
    input  logic [31:0]             fetch_address,
    output logic                    fetch_ready,
    output logic [31:0]             fetch_data,
    input  logic                    data_request,
    input  logic                    data_write,
    input  logic [3:0]              data_byte_enable,
    input  logic [31:0]             data_address,
    input  logic [31:0]             data_write_data,
    output logic                    data_ready,
    output logic [31:0]             data_read_data,
    output logic                    mem_read_enable,
    output logic                    mem_write_enable,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [31:0]             mem_write_data,
    input  logic [31:0]             mem_read_data
);

    typedef enum logic {IDLE, READ_WAIT} state_t;
    typedef enum logic {FETCH, DATA} port_t;

    state_t                  state, state_next;
    port_t                   owner, last_grant;
    logic [ADDRESS_SIZE-1:0] address_q;
    logic [31:0]             write_data_q;
    logic [3:0]              byte_enable_q;
    logic                    write_q;

    logic                    fetch_eligible, data_eligible;
    logic                    grant_fetch, grant_data;
    logic                    read_strobe, write_strobe;
    logic                    set_fetch_ready, set_data_ready;
    logic                    capture_fetch, capture_data;
    logic [31:0]             write_word;
    logic [ADDRESS_SIZE-1:0] address_word;

    // Byte-offset and aliased upper address bits are deliberately dropped.
    logic unused_address_bits;
    assign unused_address_bits = ^{fetch_address[1:0], fetch_address[31:ADDRESS_SIZE+2],
                                   data_address[1:0],  data_address[31:ADDRESS_SIZE+2]};

    assign fetch_eligible = fetch_request && !fetch_ready;
    assign data_eligible  = data_request && !data_ready;

    always_comb begin
        state_next      = state;
        grant_fetch     = 1'b0;
        grant_data      = 1'b0;
        read_strobe     = 1'b0;
        write_strobe    = 1'b0;
        set_fetch_ready = 1'b0;
        set_data_ready  = 1'b0;
        capture_fetch   = 1'b0;
        capture_data    = 1'b0;
        write_word      = data_write_data;
        address_word    = fetch_address[ADDRESS_SIZE+1:2];
        case (state)
            IDLE: begin
                if (fetch_eligible && (!data_eligible || last_grant == DATA)) begin
                    grant_fetch = 1'b1;
                end else if (data_eligible) begin
                    grant_data = 1'b1;
                end
                if (grant_data) begin
                    address_word = data_address[ADDRESS_SIZE+1:2];
                end
                if (grant_fetch) begin
                    read_strobe = 1'b1;
                    state_next  = READ_WAIT;
                end else if (grant_data) begin
                    if (!data_write) begin
                        read_strobe = 1'b1;
                        state_next  = READ_WAIT;
                    end else if (data_byte_enable == 4'b1111) begin
                        write_strobe   = 1'b1;
                        set_data_ready = 1'b1;
                    end else if (data_byte_enable == 4'b0000) begin
                        set_data_ready = 1'b1;
                    end else begin
                        read_strobe = 1'b1;
                        state_next  = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                address_word = address_q;
                state_next   = IDLE;
                // Only partial stores reach READ_WAIT with the write flag set; merge while read data is live.
                if (write_q) begin
                    write_strobe = 1'b1;
                    for (int unsigned i = 0; i < 4; i++) begin
                        write_word[8*i +: 8] = byte_enable_q[i] ? write_data_q[8*i +: 8]
                                                                : mem_read_data[8*i +: 8];
                    end
                    set_data_ready = 1'b1;
                end else if (owner == FETCH) begin
                    capture_fetch   = 1'b1;
                    set_fetch_ready = 1'b1;
                end else begin
                    capture_data   = 1'b1;
                    set_data_ready = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_read_enable  = read_strobe && reset_n;
    assign mem_write_enable = write_strobe && reset_n;
    assign mem_address      = address_word;
    assign mem_write_data   = write_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            owner          <= FETCH;
            last_grant     <= DATA;
            address_q      <= '0;
            write_data_q   <= '0;
            byte_enable_q  <= '0;
            write_q        <= 1'b0;
            fetch_ready    <= 1'b0;
            data_ready     <= 1'b0;
            fetch_data     <= '0;
            data_read_data <= '0;
        end else begin
            state       <= state_next;
            fetch_ready <= set_fetch_ready;
            data_ready  <= set_data_ready;
            if (capture_fetch) begin
                fetch_data <= mem_read_data;
            end
            if (capture_data) begin
                data_read_data <= mem_read_data;
            end
            if (grant_fetch) begin
                owner      <= FETCH;
                last_grant <= FETCH;
                address_q  <= fetch_address[ADDRESS_SIZE+1:2];
                write_q    <= 1'b0;
            end else if (grant_data) begin
                owner         <= DATA;
                last_grant    <= DATA;
                address_q     <= data_address[ADDRESS_SIZE+1:2];
                write_data_q  <= data_write_data;
                byte_enable_q <= data_byte_enable;
                write_q       <= data_write;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: vector table, hand-written arbitration/reset sequences,
// and randomized traffic checked against a transaction-level memory model.
module tb_memory_arbiter;

    localparam int AS = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          fetch_request = 1'b0;
    logic [31:0]   fetch_address = '0;
    logic          fetch_ready;
    logic [31:0]   fetch_data;
    logic          data_request = 1'b0;
    logic          data_write = 1'b0;
    logic [3:0]    data_byte_enable = '0;
    logic [31:0]   data_address = '0;
    logic [31:0]   data_write_data = '0;
    logic          data_ready;
    logic [31:0]   data_read_data;
    logic          mem_read_enable;
    logic          mem_write_enable;
    logic [AS-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.ADDRESS_SIZE(AS)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fetch_request    (fetch_request),
        .fetch_address    (fetch_address),
        .fetch_ready      (fetch_ready),
        .fetch_data       (fetch_data),
        .data_request     (data_request),
        .data_write       (data_write),
        .data_byte_enable (data_byte_enable),
        .data_address     (data_address),
        .data_write_data  (data_write_data),
        .data_ready       (data_ready),
        .data_read_data   (data_read_data),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    // Block memory model with one-cycle registered read.
    logic [31:0] mem [0:4095];
    int rd_cnt = 0;
    int wr_cnt = 0;
    always @(posedge clk) begin
        if (reset_n) begin
            checks++;
            if (mem_read_enable && mem_write_enable) begin
                errors++;
                $display("FAIL strobe_exclusive: read=1 write=1, required at most one high");
            end
        end
        if (mem_write_enable) begin
            mem[mem_address] = mem_write_data;
            wr_cnt++;
        end
        if (mem_read_enable) begin
            mem_read_data <= mem[mem_address];
            rd_cnt++;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] word_of(input logic [31:0] a);
        return a[13:2];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom();
        a[13:2] = 12'($urandom_range(0, 7));
        return a;
    endfunction

    typedef struct {
        string       name;
        bit          is_fetch;
        bit          wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        int          lat;
        int          rds;
        int          wrs;
        bit          n_re;
        bit          n_we;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mem;
    } vec_t;

    task automatic run_vec(input vec_t v);
        logic [11:0] w;
        int rd0, wr0, lat;
        bit got;
        w = word_of(v.addr);
        @(negedge clk);
        mem[w] = v.init;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        if (v.is_fetch) begin
            fetch_request = 1'b1;
            fetch_address = v.addr;
        end else begin
            data_request     = 1'b1;
            data_write       = v.wr;
            data_byte_enable = v.be;
            data_address     = v.addr;
            data_write_data  = v.wdata;
        end
        #1;
        check32({v.name, "_addr"}, 32'(mem_address), 32'(w));
        check32({v.name, "_re_n"}, 32'(mem_read_enable), 32'(v.n_re));
        check32({v.name, "_we_n"}, 32'(mem_write_enable), 32'(v.n_we));
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (v.is_fetch ? fetch_ready : data_ready) begin
                got = 1'b1;
                lat = c;
            end
        end
        fetch_request = 1'b0;
        data_request  = 1'b0;
        check32({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        if (!v.wr) check32({v.name, "_rdata"}, v.is_fetch ? fetch_data : data_read_data, v.exp_rdata);
        check32({v.name, "_mem"}, mem[w], v.exp_mem);
        check32({v.name, "_reads"}, 32'(rd_cnt - rd0), 32'(v.rds));
        check32({v.name, "_writes"}, 32'(wr_cnt - wr0), 32'(v.wrs));
        @(negedge clk);
        check32({v.name, "_pulse_end"}, 32'(v.is_fetch ? fetch_ready : data_ready), 32'd0);
        if (!v.wr) check32({v.name, "_rdata_held"}, v.is_fetch ? fetch_data : data_read_data, v.exp_rdata);
    endtask

    vec_t vecs[10];
    logic [31:0] refmem [0:4095];

    initial begin
        logic [3:0]  order;
        int          n_ev;
        logic [11:0] w;
        int          wr0, spurious;
        bit          f_busy, d_busy, pf, pd, d_wr;
        logic [31:0] f_addr, d_addr, d_wdata;
        logic [3:0]  d_be;
        int          f_wait, d_wait, r;

        vecs[0] = '{"fetch_w4",   1, 0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 2, 1, 0, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{"store_full", 0, 1, 4'hF, 32'h0000_0020, 32'h12345678,  32'h0,        1, 0, 1, 0, 1, 32'h0,        32'h12345678};
        vecs[2] = '{"store_b2",   0, 1, 4'h4, 32'h0000_0020, 32'h00AB0000,  32'h11223344, 2, 1, 1, 1, 0, 32'h0,        32'h11AB3344};
        vecs[3] = '{"store_none", 0, 1, 4'h0, 32'h0000_0024, 32'hFFFFFFFF,  32'hCAFEF00D, 1, 0, 0, 0, 0, 32'h0,        32'hCAFEF00D};
        vecs[4] = '{"load_low",   0, 0, 4'hF, 32'h0000_0003, 32'h0,         32'hA5A55A5A, 2, 1, 0, 1, 0, 32'hA5A55A5A, 32'hA5A55A5A};
        vecs[5] = '{"load_alias", 0, 0, 4'h0, 32'h0001_4008, 32'h0,         32'h01020304, 2, 1, 0, 1, 0, 32'h01020304, 32'h01020304};
        vecs[6] = '{"store_b30",  0, 1, 4'h9, 32'h0000_0030, 32'hAA0000BB,  32'h11223344, 2, 1, 1, 1, 0, 32'h0,        32'hAA2233BB};
        vecs[7] = '{"fetch_top",  1, 0, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h77777777, 2, 1, 0, 1, 0, 32'h77777777, 32'h77777777};
        vecs[8] = '{"store_lo16", 0, 1, 4'h3, 32'h0000_0040, 32'h0000BEEF,  32'h12345678, 2, 1, 1, 1, 0, 32'h0,        32'h1234BEEF};
        vecs[9] = '{"store_wrap", 0, 1, 4'hF, 32'hFFFF_0028, 32'h0BADF00D,  32'h0,        1, 0, 1, 0, 1, 32'h0,        32'h0BADF00D};

        // Reset state, with a request pending to show the strobe is held off.
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0010;
        repeat (2) @(negedge clk);
        check32("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check32("rst_data_ready", 32'(data_ready), 32'd0);
        check32("rst_fetch_data", fetch_data, 32'd0);
        check32("rst_data_read_data", data_read_data, 32'd0);
        check32("rst_mem_re", 32'(mem_read_enable), 32'd0);
        check32("rst_mem_we", 32'(mem_write_enable), 32'd0);
        fetch_request = 1'b0;
        reset_n = 1'b1;

        // Both ports requesting from reset: fetch wins first, then strict alternation.
        @(negedge clk);
        mem[word_of(32'h60)] = 32'h0F0F0F0F;
        mem[word_of(32'h50)] = 32'hD0D0D0D0;
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0060;
        data_request  = 1'b1;
        data_write    = 1'b0;
        data_address  = 32'h0000_0050;
        #1;
        check32("tie_first_addr", 32'(mem_address), 32'h18);
        check32("tie_first_re", 32'(mem_read_enable), 32'd1);
        order = '0;
        n_ev = 0;
        for (int c = 0; c < 20 && n_ev < 4; c++) begin
            @(negedge clk);
            if (fetch_ready) begin
                check32("tie_fetch_data", fetch_data, 32'h0F0F0F0F);
                n_ev++;
            end
            if (data_ready) begin
                check32("tie_data_data", data_read_data, 32'hD0D0D0D0);
                order[n_ev] = 1'b1;
                n_ev++;
            end
        end
        fetch_request = 1'b0;
        data_request  = 1'b0;
        check32("tie_event_count", 32'(n_ev), 32'd4);
        check32("tie_grant_order", 32'(order), 32'b1010);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset asserted in the merge cycle of a partial store.
        w = word_of(32'h70);
        @(negedge clk);
        mem[w] = 32'h11223344;
        wr0 = wr_cnt;
        data_request     = 1'b1;
        data_write       = 1'b1;
        data_byte_enable = 4'b0001;
        data_address     = 32'h0000_0070;
        data_write_data  = 32'h000000EE;
        @(negedge clk);
        #1;
        check32("rmw_pre_we", 32'(mem_write_enable), 32'd1);
        check32("rmw_pre_wdata", mem_write_data, 32'h112233EE);
        reset_n = 1'b0;
        #1;
        check32("rmw_rst_we", 32'(mem_write_enable), 32'd0);
        check32("rmw_rst_re", 32'(mem_read_enable), 32'd0);
        data_request = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_ready) spurious++;
        end
        check32("rmw_rst_no_ready", 32'(spurious), 32'd0);
        check32("rmw_rst_mem", mem[w], 32'h11223344);
        check32("rmw_rst_writes", 32'(wr_cnt - wr0), 32'd0);
        run_vec('{"after_rst", 0, 1, 4'hF, 32'h0000_0070, 32'h55667788, 32'h11223344, 1, 0, 1, 0, 1, 32'h0, 32'h55667788});

        // Randomized traffic on both ports against a transaction-level memory model.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            mem[i]    = $urandom();
            refmem[i] = mem[i];
        end
        f_busy = 0; d_busy = 0; pf = 0; pd = 0;
        f_wait = 0; d_wait = 0;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; d_wr = 0;
        for (int cyc = 0; cyc < 640; cyc++) begin
            @(negedge clk);
            if (fetch_ready) begin
                checks++;
                if (!f_busy || pf) begin
                    errors++;
                    $display("FAIL rand_fetch_pulse: fetch_ready=1 busy=%0d prev=%0d, required busy=1 prev=0", f_busy, pf);
                end else begin
                    check32("rand_fetch_data", fetch_data, refmem[word_of(f_addr)]);
                    f_busy = 0;
                end
            end
            if (data_ready) begin
                checks++;
                if (!d_busy || pd) begin
                    errors++;
                    $display("FAIL rand_data_pulse: data_ready=1 busy=%0d prev=%0d, required busy=1 prev=0", d_busy, pd);
                end else begin
                    if (d_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (d_be[b]) refmem[word_of(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
                    end else begin
                        check32("rand_load_data", data_read_data, refmem[word_of(d_addr)]);
                    end
                    d_busy = 0;
                end
            end
            pf = fetch_ready;
            pd = data_ready;
            if (f_busy && ++f_wait > 12) begin
                check32("rand_fetch_timeout", 32'(f_wait), 32'd12);
                f_busy = 0;
            end
            if (d_busy && ++d_wait > 12) begin
                check32("rand_data_timeout", 32'(d_wait), 32'd12);
                d_busy = 0;
            end
            if (!f_busy && cyc < 600 && $urandom_range(0, 3) != 0) begin
                f_busy = 1;
                f_wait = 0;
                f_addr = rand_addr();
            end
            if (!d_busy && cyc < 600 && $urandom_range(0, 3) != 0) begin
                d_busy  = 1;
                d_wait  = 0;
                d_addr  = rand_addr();
                d_wr    = 1'($urandom_range(0, 1));
                d_wdata = $urandom();
                r = $urandom_range(0, 3);
                d_be = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            fetch_request    = f_busy;
            fetch_address    = f_addr;
            data_request     = d_busy;
            data_write       = d_wr;
            data_byte_enable = d_be;
            data_address     = d_addr;
            data_write_data  = d_wdata;
        end
        check32("rand_drained", 32'({f_busy, d_busy}), 32'd0);
        for (int i = 0; i < 8; i++) check32("rand_final_mem", mem[i], refmem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one single-port block memory (one-cycle registered read latency, single-cycle write) between the instruction-fetch requester and the load/store requester. Performs round-robin arbitration, latches the winning request, and sequences the memory: plain reads, full-word writes, and read-modify-write for byte and half-word stores. Sits between the core's fetch and load/store units and the `block_memory` instance.

## Interface
- `ADDRESS_SIZE`, 12: word-address width of the memory; memory word index = byte address bits `[ADDRESS_SIZE+1:2]`.

- `clk` in 1: single clock; all state on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fetch_request` in 1: fetch read request; held with address until `fetch_ready`.
- `fetch_address` in 32: fetch byte address.
- `fetch_ready` out 1: one-cycle completion pulse; `fetch_data` is valid in this cycle.
- `fetch_data` out 32: read word; held until the next fetch completion.
- `data_request` in 1: load/store request; held with all fields until `data_ready`.
- `data_write` in 1: 1 = store, 0 = load.
- `data_byte_enable` in 4: store lane mask; bit i selects byte i; ignored for loads.
- `data_address` in 32: data byte address.
- `data_write_data` in 32: store data, already lane-aligned.
- `data_ready` out 1: one-cycle completion pulse.
- `data_read_data` out 32: load word, valid with `data_ready` and held until the next data completion.
- `mem_read_enable` out 1: memory read strobe.
- `mem_write_enable` out 1: memory write strobe.
- `mem_address` out `ADDRESS_SIZE`: memory word address.
- `mem_write_data` out 32: memory write word.
- `mem_read_data` in 32: memory read word, valid in the cycle after `mem_read_enable`.

## Operation
- States: IDLE, READ_WAIT, MERGE_WRITE. The block also holds an `owner` register (FETCH/DATA) and a `last_grant` register.
- A port is eligible in IDLE if its request is high and its ready output is not high in that cycle. This prevents re-issuing a request that is being completed.
- Arbitration in IDLE:
  - One port eligible: that port wins.
  - Both eligible: the port other than `last_grant` wins.
  - On a grant, update `last_grant` and `owner`, and latch the address, write data, byte enables and write flag.
- Grant actions (combinational in the IDLE grant cycle, using the live request fields):
  - Fetch, or data load: `mem_read_enable`=1, go to READ_WAIT.
  - Data store with mask 1111: `mem_write_enable`=1, `mem_write_data`=`data_write_data`, register `data_ready`, stay in IDLE.
  - Data store with mask 0000: no memory access, register `data_ready`, stay in IDLE.
  - Data store with any other mask: `mem_read_enable`=1, go to READ_WAIT with the merge flag set.
- READ_WAIT:
  - Merge flag clear: capture `mem_read_data` into the owner's data register, register the owner's ready pulse, go to IDLE.
  - Merge flag set: go to MERGE_WRITE.
- Correction to the READ_WAIT merge path: the merge is performed in READ_WAIT itself, using `mem_read_data`, which is valid only in that cycle. In READ_WAIT with the merge flag set:
  - `mem_write_enable`=1.
  - `mem_write_data` byte i = latched `data_write_data` byte i if mask bit i is set, else `mem_read_data` byte i.
  - Register `data_ready` and go to IDLE.
  - MERGE_WRITE is therefore unused and must be removed. Final states: IDLE, READ_WAIT.
- `mem_address` = latched address `[ADDRESS_SIZE+1:2]` in READ_WAIT, and live requester address bits in IDLE.
  - Address bits `[1:0]` are ignored.
  - Higher address bits alias (wrap) silently.
- `mem_read_enable` and `mem_write_enable` are never high together, and both are forced to 0 while `reset_n`=0.
- If a request is dropped before its ready pulse, the transaction still completes and the pulse is still produced.

## Timing
- Reset (asynchronous):
  - State IDLE; `last_grant`=DATA, so fetch wins the first tie.
  - `fetch_ready`, `data_ready`, `fetch_data` and `data_read_data` = 0.
  - Memory strobes = 0.
- Reset during READ_WAIT abandons the transaction: no ready pulse, and no merge write occurs.
- Read (fetch or load): request sampled in cycle n → `mem_read_enable` in n → data captured at the end of n+1 → ready high in n+2.
- Full-word store, or mask 0000: request in n → write in n → `data_ready` in n+1.
- Partial store: request in n → read in n → merge write in n+1 → `data_ready` in n+2.
- A ready pulse lasts exactly one cycle.
- In the cycle a port's ready is high, IDLE may grant the other port.
- Minimum interval between grants is 1 cycle for writes and 2 cycles for reads and partial stores.

## Test plan
- Fetch 0x0000_0010 with memory word 4 = 0xDEADBEEF:
  - `mem_read_enable` with `mem_address`=4 in cycle n.
  - `fetch_ready`=1 and `fetch_data`=0xDEADBEEF in n+2, for one cycle only.
- Store word 0x12345678 at 0x20, mask 1111: single write to address 8, `data_ready` in n+1, no read strobe.
- Store at 0x20 with mask 0100 and data 0x00AB0000, over an old word 0x11223344:
  - Read in n, write of 0x11AB3344 in n+1, `data_ready` in n+2.
- Fetch and load both requesting from reset:
  - Fetch is granted first, then the load.
  - With both held continuously, grants alternate fetch/data/fetch.
- Store with mask 0000: no strobes, `data_ready` in n+1, memory unchanged.
- Assert `reset_n`=0 in the READ_WAIT cycle of a partial store:
  - Strobes drop immediately, no write occurs, no ready pulse.
  - After release, state is IDLE and the next request completes normally.
